// File: rtl/wb_regfile_pkg.sv
// Shared constants for the architectural register file: register roles,
// overflow error codes and datapath widths.
package wb_regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_IDX_W    = $clog2(RF_NUM_REGS);

  localparam logic [RF_IDX_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [RF_IDX_W-1:0] REG_STATUS = 5'd30;
  localparam logic [RF_IDX_W-1:0] REG_LINK   = 5'd31;

  // Codes the ALU writes into rstatus when an arithmetic op overflows
  typedef enum logic [RF_DATA_W-1:0] {
    ERR_NONE = 32'd0,
    ERR_ADD  = 32'd1,
    ERR_ADDI = 32'd2,
    ERR_SUB  = 32'd3,
    ERR_MUL  = 32'd4,
    ERR_DIV  = 32'd5
  } err_code_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: $r0 gating, then same-cycle write bypass,
// then the stored array value.
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [DATA_W-1:0] rd_array_data_i,
  input  logic              byp_en_i,
  input  logic [IDX_W-1:0]  byp_idx_i,
  input  logic [DATA_W-1:0] byp_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic idx_is_zero;
  logic byp_hit;

  assign idx_is_zero = (rd_idx_i == '0);
  assign byp_hit     = byp_en_i && (byp_idx_i == rd_idx_i);

  always_comb begin
    rd_data_o = rd_array_data_i;
    if (idx_is_zero) begin
      rd_data_o = '0;
    end else if (byp_hit) begin
      rd_data_o = byp_data_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file fed by writeback: one write per cycle, two
// bypassed combinational read ports, and rstatus error tracking.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int DATA_W     = RF_DATA_W,
  parameter int STATUS_REG = int'(REG_STATUS),
  parameter int ERRCNT_W   = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        write_ctrl,
  input  logic [$clog2(NUM_REGS)-1:0] write_reg,
  input  logic [DATA_W-1:0]           write_data,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_readRegA,
  input  logic [$clog2(NUM_REGS)-1:0] ctrl_readRegB,
  input  logic                        clear_err,
  output logic [DATA_W-1:0]           data_readRegA,
  output logic [DATA_W-1:0]           data_readRegB,
  output logic                        err_sticky,
  output logic [ERRCNT_W-1:0]         err_count,
  output logic [DATA_W-1:0]           last_err
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(STATUS_REG);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (v == '1) ? v : v + ERRCNT_W'(1);
  endfunction

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                sticky_q, sticky_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   last_q, last_d;

  logic wr_en;
  logic status_err_wr;
  logic byp_en;

  assign wr_en         = write_ctrl && (write_reg != '0);
  assign status_err_wr = write_ctrl && (write_reg == STATUS_IDX) && (write_data != '0);
  // Bypass is suppressed during reset because the write will be dropped
  assign byp_en        = write_ctrl && reset_n;

  // A nonzero rstatus write overrides a simultaneous clear
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (clear_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (status_err_wr) begin
      sticky_d = 1'b1;
      last_d   = write_data;
      cnt_d    = sat_inc(clear_err ? '0 : cnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) begin
        regs_q[write_reg] <= write_data;
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_port_a (
    .rd_idx_i        (ctrl_readRegA),
    .rd_array_data_i (regs_q[ctrl_readRegA]),
    .byp_en_i        (byp_en),
    .byp_idx_i       (write_reg),
    .byp_data_i      (write_data),
    .rd_data_o       (data_readRegA)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_port_b (
    .rd_idx_i        (ctrl_readRegB),
    .rd_array_data_i (regs_q[ctrl_readRegB]),
    .byp_en_i        (byp_en),
    .byp_idx_i       (write_reg),
    .byp_data_i      (write_data),
    .rd_data_o       (data_readRegB)
  );

  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;
  assign last_err   = last_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, hand sequences, and random
// traffic against a behavioural model.
module tb_wb_regfile;

  logic        clock;
  logic        reset_n;
  logic        write_ctrl;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        clear_err;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic [31:0] last_err;

  wb_regfile dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .write_ctrl    (write_ctrl),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .clear_err     (clear_err),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .err_sticky    (err_sticky),
    .err_count     (err_count),
    .last_err      (last_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_sticky;
  int          m_cnt;
  logic [31:0] m_last;

  typedef struct {
    logic        rst_n;
    logic        wc;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        clr;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        es;
    logic [7:0]  ec;
    logic [31:0] el;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic r, logic w, logic [4:0] wrg, logic [31:0] wdat,
                              logic [4:0] a, logic [4:0] b, logic c,
                              logic [31:0] ea, logic [31:0] eb, logic es,
                              logic [7:0] ec, logic [31:0] el);
    vec_t v;
    v.rst_n = r; v.wc = w; v.wr = wrg; v.wd = wdat; v.ra = a; v.rb = b; v.clr = c;
    v.ea = ea; v.eb = eb; v.es = es; v.ec = ec; v.el = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wrg,
                       input logic [31:0] wdat, input logic [4:0] a,
                       input logic [4:0] b, input logic c);
    @(negedge clock);
    reset_n = r; write_ctrl = w; write_reg = wrg; write_data = wdat;
    ctrl_readRegA = a; ctrl_readRegB = b; clear_err = c;
    #2;
  endtask

  // Reads follow the architectural rules: $r0 is zero, a live write is visible
  // immediately unless reset is asserted, otherwise the stored value.
  function automatic logic [31:0] m_read(logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (write_ctrl && reset_n && write_reg == idx) return write_data;
    return m_regs[idx];
  endfunction

  function automatic void m_step();
    if (!reset_n) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_sticky = 0; m_cnt = 0; m_last = 32'h0;
    end else begin
      if (write_ctrl && write_reg != 0) m_regs[write_reg] = write_data;
      if (clear_err) begin
        m_sticky = 0; m_cnt = 0;
      end
      if (write_ctrl && write_reg == 30 && write_data != 0) begin
        m_sticky = 1;
        m_last   = write_data;
        m_cnt    = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end
  endfunction

  task automatic commit();
    @(posedge clock);
    m_step();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rdA"},    data_readRegA, m_read(ctrl_readRegA));
    chk({tag, ".rdB"},    data_readRegB, m_read(ctrl_readRegB));
    chk({tag, ".sticky"}, {31'h0, err_sticky}, {31'h0, m_sticky});
    chk({tag, ".count"},  {24'h0, err_count}, m_cnt);
    chk({tag, ".last"},   last_err, m_last);
  endtask

  initial begin
    reset_n = 1'b0; write_ctrl = 1'b0; write_reg = '0; write_data = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0; clear_err = 1'b0;

    tbl[0]  = mk(0, 1,  7, 32'h12,       7,  7, 0, 32'h0,        32'h0,        0, 0, 32'h0);
    tbl[1]  = mk(1, 0,  0, 32'h0,        7,  0, 0, 32'h0,        32'h0,        0, 0, 32'h0);
    tbl[2]  = mk(1, 1,  7, 32'h12,       7,  0, 0, 32'h12,       32'h0,        0, 0, 32'h0);
    tbl[3]  = mk(1, 0,  0, 32'h0,        7,  7, 0, 32'h12,       32'h12,       0, 0, 32'h0);
    tbl[4]  = mk(1, 1,  5, 32'hDEADBEEF, 7,  5, 0, 32'h12,       32'hDEADBEEF, 0, 0, 32'h0);
    tbl[5]  = mk(1, 0,  0, 32'h0,        5,  0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0);
    tbl[6]  = mk(1, 1,  0, 32'hFFFFFFFF, 0,  0, 0, 32'h0,        32'h0,        0, 0, 32'h0);
    tbl[7]  = mk(1, 0,  0, 32'h0,        0,  5, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0);
    tbl[8]  = mk(1, 1, 30, 32'h3,       30, 30, 0, 32'h3,        32'h3,        0, 0, 32'h0);
    tbl[9]  = mk(1, 1, 30, 32'h0,       30,  1, 0, 32'h0,        32'h0,        1, 1, 32'h3);
    tbl[10] = mk(1, 1, 30, 32'h4,       30, 30, 0, 32'h4,        32'h4,        1, 1, 32'h3);
    tbl[11] = mk(1, 0,  0, 32'h0,       30,  0, 0, 32'h4,        32'h0,        1, 2, 32'h4);
    tbl[12] = mk(1, 0,  0, 32'h0,       30,  0, 1, 32'h4,        32'h0,        1, 2, 32'h4);
    tbl[13] = mk(1, 0,  0, 32'h0,        0,  0, 0, 32'h0,        32'h0,        0, 0, 32'h4);
    tbl[14] = mk(1, 1, 30, 32'h1,       30,  0, 1, 32'h1,        32'h0,        0, 0, 32'h4);
    tbl[15] = mk(1, 0,  0, 32'h0,       30,  0, 0, 32'h1,        32'h0,        1, 1, 32'h1);
    tbl[16] = mk(0, 1,  5, 32'hAAAA,     5, 30, 0, 32'hDEADBEEF, 32'h1,        1, 1, 32'h1);
    tbl[17] = mk(1, 0,  0, 32'h0,        5, 30, 0, 32'h0,        32'h0,        0, 0, 32'h0);

    // Bring array out of X before the directed vectors
    drive(0, 0, 0, 0, 0, 0, 0);
    commit();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst_n, tbl[i].wc, tbl[i].wr, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].clr);
      chk($sformatf("vec%0d.rdA", i),    data_readRegA, tbl[i].ea);
      chk($sformatf("vec%0d.rdB", i),    data_readRegB, tbl[i].eb);
      chk($sformatf("vec%0d.sticky", i), {31'h0, err_sticky}, {31'h0, tbl[i].es});
      chk($sformatf("vec%0d.count", i),  {24'h0, err_count}, {24'h0, tbl[i].ec});
      chk($sformatf("vec%0d.last", i),   last_err, tbl[i].el);
      commit();
    end

    // Every index reads zero on both ports after reset
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 5'(i), 5'(31 - i), 0);
      chk($sformatf("zero.A%0d", i), data_readRegA, 32'h0);
      chk($sformatf("zero.B%0d", i), data_readRegB, 32'h0);
      commit();
    end

    // 260 back-to-back nonzero rstatus writes saturate the counter
    for (int i = 1; i <= 260; i++) begin
      drive(1, 1, 30, 32'(i), 30, 0, 0);
      commit();
    end
    drive(1, 1, 30, 32'h5, 30, 30, 1);
    chk("sat.count", {24'h0, err_count}, 32'd255);
    chk("sat.last", last_err, 32'd260);
    chk("sat.byp", data_readRegA, 32'h5);
    commit();
    drive(1, 0, 0, 0, 30, 0, 0);
    chk("clrwin.count", {24'h0, err_count}, 32'd1);
    chk("clrwin.last", last_err, 32'h5);
    chk("clrwin.sticky", {31'h0, err_sticky}, 32'h1);
    chk("clrwin.reg30", data_readRegA, 32'h5);
    commit();

    // Random traffic with narrow index ranges to force collisions
    for (int n = 0; n < 1500; n++) begin
      logic       r, w, c;
      logic [4:0] wrg, a, b;
      logic [31:0] wdat;
      r    = ($urandom_range(0, 49) != 0);
      w    = ($urandom_range(0, 3) != 0);
      wrg  = ($urandom_range(0, 2) == 0) ? 5'd30 : 5'($urandom_range(0, 7));
      wdat = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      a    = ($urandom_range(0, 4) == 0) ? 5'd30 : 5'($urandom_range(0, 7));
      b    = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      c    = ($urandom_range(0, 19) == 0);
      drive(r, w, wrg, wdat, a, b, c);
      chk_model($sformatf("rnd%0d", n));
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural register file on the receiving end of the writeback stage's register-write interface.
- Accepts one write per cycle (write_ctrl / write_reg / write_data) and serves two combinational read ports to decode.
- Same-cycle write-to-read bypass, so decode never sees a stale value.
- Tracks overflow error codes landing in $r30 (rstatus) with a sticky flag and a saturating error counter for debug/exception logic.

Parameters:
- NUM_REGS, 32, number of architectural registers; register index width is log2(NUM_REGS) = 5.
- DATA_W, 32, register data width.
- STATUS_REG, 30, index of rstatus; target of overflow error codes and setx.
- ERRCNT_W, 8, width of the saturating error-write counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- write_ctrl  in  1  write enable from writeback.
- write_reg  in  5  destination register index.
- write_data  in  32  data to write.
- ctrl_readRegA  in  5  read port A index.
- ctrl_readRegB  in  5  read port B index.
- clear_err  in  1  clears err_sticky and err_count.
- data_readRegA  out  32  read port A data, combinational.
- data_readRegB  out  32  read port B data, combinational.
- err_sticky  out  1  set once any nonzero value is written to rstatus.
- err_count  out  8  saturating count of nonzero writes to rstatus.
- last_err  out  32  most recent nonzero value written to rstatus.

Behaviour:
- Reset:
  - While reset_n=0 at a rising edge, all registers clear to 0, err_sticky=0, err_count=0, last_err=0.
  - A write presented in a reset cycle is dropped.
  - Reads during reset return the current array contents; bypass is disabled while reset_n=0.
- Write:
  - If write_ctrl=1 and write_reg!=0 at a rising edge, reg[write_reg] <= write_data. Latency 1 cycle into the array.
  - Writes to $r0 are discarded; $r0 always reads 0.
- Read:
  - data_readRegX = 0 if ctrl_readRegX==0.
  - Otherwise, if write_ctrl && reset_n && write_reg==ctrl_readRegX, the result is write_data (bypass).
  - Otherwise the result is reg[ctrl_readRegX].
  - Both ports may address the same register or the write target simultaneously; each port resolves independently.
- Status tracking, on a qualifying write to STATUS_REG with write_data!=0:
  - err_sticky <= 1.
  - last_err <= write_data.
  - err_count <= err_count+1, saturating at 255. It holds at 255 and never wraps.
  - A zero write to rstatus updates the register but not err_*.
  - setx values are counted like error codes: any nonzero rstatus write counts.
- clear_err:
  - clear_err=1 clears err_sticky and err_count to 0; last_err is unchanged.
  - If clear_err coincides with a nonzero rstatus write, the write wins: err_sticky=1, err_count=1, last_err updated.
- No stalls and no handshake: one write accepted every cycle unconditionally.

Decomposition:
- Shared package holds:
  - REG_ZERO=0, REG_STATUS=30, REG_LINK=31.
  - Error code constants: ERR_ADD=1, ERR_ADDI=2, ERR_SUB=3, ERR_MUL=4, ERR_DIV=5.
  - DATA_W and register-index width.
- One natural sub-module, regfile_read_port: index compare, bypass mux, zero gating. Instantiated twice.
- Storage, write decode and status logic live in the top module.

Test Plan:
- Reset then read all 32 indices on both ports -> all 0, err_sticky=0, err_count=0.
- Write $r5=0xDEADBEEF, next cycle read A=5 -> 0xDEADBEEF. In the same cycle as the write, read B=5 -> 0xDEADBEEF via bypass.
- Write $r0=0xFFFFFFFF with write_ctrl=1, then read A=0 and B=0 -> both 0, including in the write cycle.
- Write $r30=3, then $r30=0, then $r30=4 -> err_count=2, last_err=4, err_sticky=1, reg30=4. Then clear_err -> err_sticky=0, err_count=0, last_err=4.
- 260 consecutive nonzero $r30 writes -> err_count saturates at 255. clear_err together with a write of 5 -> err_count=1, last_err=5.
- Write $r7=0x12 in a cycle with reset_n=0 -> $r7 reads 0 after reset; a write after reset_n=1 takes effect normally.
